// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the load/store path: opcodes, load/store
// funct3 encodings and the data-memory responder state type.
package rv32i_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/data_mem_unit_if.sv
// Request/response bundle between the core's memory stage and the data memory.
interface data_mem_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        misalign_err;

   modport master (
      output req_valid, mem_read, mem_write, funct3, addr, wdata,
      input  req_ready, resp_valid, rdata, misalign_err
   );

   modport slave (
      input  req_valid, mem_read, mem_write, funct3, addr, wdata,
      output req_ready, resp_valid, rdata, misalign_err
   );

endinterface

// File: rtl/data_mem_unit_lane_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, replicated store
// data, shifted/extended load data and the access-legality check.
module dm_lane_align
   import rv32i_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [31:0] wdata,
   input  logic [31:0] raw_word,
   output logic [3:0]  byte_en,
   output logic [31:0] wword,
   output logic [31:0] load_data,
   output logic        err
);

   logic [31:0] shifted;

   always_comb begin
      byte_en   = '0;
      wword     = wdata;
      load_data = '0;
      err       = 1'b0;
      shifted   = raw_word >> {addr_lo, 3'b000};

      // Store data is replicated across lanes so byte_en alone picks the target.
      case (funct3)
         F3_B, F3_BU: begin
            byte_en   = 4'b0001 << addr_lo;
            wword     = {4{wdata[7:0]}};
            load_data = (funct3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                         : {24'h0, shifted[7:0]};
         end
         F3_H, F3_HU: begin
            err       = addr_lo[0];
            byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
            wword     = {2{wdata[15:0]}};
            load_data = (funct3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                         : {16'h0, shifted[15:0]};
         end
         F3_W: begin
            err       = (addr_lo != 2'b00);
            byte_en   = 4'b1111;
            wword     = wdata;
            load_data = raw_word;
         end
         default: err = 1'b1;
      endcase

      if (is_store && funct3[2]) err = 1'b1;
      if (is_load && is_store)   err = 1'b1;
      if (err)                   byte_en = '0;
   end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states,
// then a single-cycle response carrying aligned/extended load data.
module data_mem_unit
   import rv32i_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   data_mem_unit_if.slave  bus
);

   localparam int DEPTH = 2 ** ADDR_W;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W+1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [2:0]        f3_q, f3_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [31:0]       mem [DEPTH];

   logic              accept;
   logic              commit;
   logic              mem_we;
   logic [ADDR_W+1:0] cur_addr;
   logic [31:0]       cur_wdata;
   logic [2:0]        cur_f3;
   logic              cur_rd;
   logic              cur_wr;
   logic [31:0]       raw_word;
   logic [3:0]        byte_en;
   logic [31:0]       wword;
   logic [31:0]       load_data;
   logic              align_err;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

   assign accept = (state_q == IDLE) && bus.req_valid && (bus.mem_read || bus.mem_write);

   // With no wait states the commit edge is the accept edge, so the live
   // request is used in IDLE and the captured copy afterwards.
   assign cur_addr  = (state_q == IDLE) ? bus.addr[ADDR_W+1:0] : addr_q;
   assign cur_wdata = (state_q == IDLE) ? bus.wdata            : wdata_q;
   assign cur_f3    = (state_q == IDLE) ? bus.funct3           : f3_q;
   assign cur_rd    = (state_q == IDLE) ? bus.mem_read         : rd_q;
   assign cur_wr    = (state_q == IDLE) ? bus.mem_write        : wr_q;

   assign raw_word = mem[cur_addr[ADDR_W+1:2]];

   dm_lane_align u_align (
      .funct3    (cur_f3),
      .addr_lo   (cur_addr[1:0]),
      .is_load   (cur_rd),
      .is_store  (cur_wr),
      .wdata     (cur_wdata),
      .raw_word  (raw_word),
      .byte_en   (byte_en),
      .wword     (wword),
      .load_data (load_data),
      .err       (align_err)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d  = bus.addr[ADDR_W+1:0];
               wdata_d = bus.wdata;
               f3_d    = bus.funct3;
               rd_d    = bus.mem_read;
               wr_d    = bus.mem_write;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      commit = (state_d == RESP) && (state_q != RESP);
      if (commit) begin
         err_d   = align_err;
         rdata_d = (cur_rd && !align_err) ? load_data : 32'h0;
      end
   end

   // A reset on the commit edge must also cancel the array write.
   assign mem_we = commit && cur_wr && !align_err && rst_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[cur_addr[ADDR_W+1:2]][8*i +: 8] <= wword[8*i +: 8];
         end
      end
   end

   assign bus.req_ready    = (state_q == IDLE);
   assign bus.resp_valid   = (state_q == RESP);
   assign bus.rdata        = rdata_q;
   assign bus.misalign_err = err_q;

endmodule
